// File: rtl/gametank_bus_pkg.sv
// Shared types and defaults for the GameTank work-RAM bus arbiter.
package gametank_bus_pkg;

   localparam int GT_AW        = 16;
   localparam int GT_DW        = 8;
   localparam int STARVE_CNT_W = 4;

   // Owner of the access whose response is due in the current cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   // Saturating increment used by the optional statistics counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/gametank_bus_arbiter.sv
// Single-port work-RAM arbiter between the 6502 CPU bus and the blitter DMA.
// One RAM access per clock; the RAM has a 1-cycle read latency. The CPU has
// priority, and a starvation counter forces a DMA win after DMA_STARVE denials.
// Optional build macro ARB_STATS_EN adds saturating grant/stall counters.
//
// rsp_owner_q | meaning
// ------------+---------------------------------------------------------
// OWN_NONE    | previous slot idle (or just out of reset), nothing due
// OWN_CPU     | CPU access issued last cycle: ack now, read data on mem_rdata
// OWN_DMA     | DMA beat issued last cycle: rvalid now if it was a read
module gametank_bus_arbiter
   import gametank_bus_pkg::*;
#(
   parameter int AW         = GT_AW,
   parameter int DW         = GT_DW,
   parameter int DMA_STARVE = 4
) (
   input  logic          sys_clk,
   input  logic          reset_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rdy,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   input  logic          stat_clr,
   output logic [15:0]   stat_cpu_cnt,
   output logic [15:0]   stat_dma_cnt,
   output logic [15:0]   stat_stall_cnt
`endif
);

   localparam logic [STARVE_CNT_W-1:0] STARVE_TH = STARVE_CNT_W'(DMA_STARVE);

   owner_e                  rsp_owner_q, rsp_owner_d;
   logic                    rsp_rd_q, rsp_rd_d;
   logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [DW-1:0]           cpu_rdata_q;
   logic                    cpu_elig, dma_force, grant_dma, grant_cpu;

   // Slot decision: CPU first unless it is in its ack cycle or DMA is starved.
   always_comb begin
      cpu_elig  = cpu_req & (rsp_owner_q != OWN_CPU);
      dma_force = (starve_cnt_q >= STARVE_TH);
      grant_dma = dma_req & (~cpu_elig | dma_force);
      grant_cpu = cpu_elig & ~grant_dma;
   end

   // RAM port is driven in the same cycle as the decision; idle slots drive zeros.
   always_comb begin
      mem_en    = grant_dma | grant_cpu;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_owner_d = OWN_NONE;
      rsp_rd_d    = 1'b0;
      if (grant_dma) begin
         mem_we      = dma_we;
         mem_addr    = dma_addr;
         mem_wdata   = dma_wdata;
         rsp_owner_d = OWN_DMA;
         rsp_rd_d    = ~dma_we;
      end else if (grant_cpu) begin
         mem_we      = cpu_we;
         mem_addr    = cpu_addr;
         mem_wdata   = cpu_wdata;
         rsp_owner_d = OWN_CPU;
         rsp_rd_d    = ~cpu_we;
      end
   end

   // Starvation counter: count denied DMA cycles, clear on grant, hold when idle.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_dma) begin
         starve_cnt_d = '0;
      end else if (dma_req && starve_cnt_q != '1) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // Response stage: read data passes straight through in the response cycle
   // and the CPU copy is held afterwards so DB_IN stays stable.
   always_comb begin
      cpu_ack    = (rsp_owner_q == OWN_CPU);
      dma_rvalid = (rsp_owner_q == OWN_DMA) & rsp_rd_q;
      dma_rdata  = dma_rvalid ? mem_rdata : '0;
      cpu_rdata  = (cpu_ack & rsp_rd_q) ? mem_rdata : cpu_rdata_q;
      cpu_rdy    = ~cpu_req | cpu_ack;
      dma_gnt    = grant_dma;
   end

   // Arbiter state; reset drops any in-flight response.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_owner_q  <= OWN_NONE;
         rsp_rd_q     <= 1'b0;
         starve_cnt_q <= '0;
         cpu_rdata_q  <= '0;
      end else begin
         rsp_owner_q  <= rsp_owner_d;
         rsp_rd_q     <= rsp_rd_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_rdata_q  <= cpu_rdata;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] stat_cpu_q, stat_dma_q, stat_stall_q;

   // Saturating grant and stall counters, clearable at run time.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_cpu_q   <= '0;
         stat_dma_q   <= '0;
         stat_stall_q <= '0;
      end else if (stat_clr) begin
         stat_cpu_q   <= '0;
         stat_dma_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         if (grant_cpu) stat_cpu_q   <= sat_inc16(stat_cpu_q);
         if (grant_dma) stat_dma_q   <= sat_inc16(stat_dma_q);
         if (!cpu_rdy)  stat_stall_q <= sat_inc16(stat_stall_q);
      end
   end

   assign stat_cpu_cnt   = stat_cpu_q;
   assign stat_dma_cnt   = stat_dma_q;
   assign stat_stall_cnt = stat_stall_q;
`endif

endmodule
